gate_sweep_checker: RTL and testbench

Self-checking sweep engine for any 2-input gate cell (nand_gate and its siblings). It sits directly upstream and downstream of the gate under test: it drives the gate's a/b inputs through all four combinations, samples the gate's y output after a programmable settle time, and compares each sample against an expected truth table. It reports the observed table, a per-vector mismatch mask and a pass flag, so gate benches and on-chip self-test need no hand-written checking.

---
 rtl/gate_sweep_checker.sv | 126 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives a 2-input gate under test through all four input
// vectors {a,b} = 0..3, holds each vector for SETTLE cycles, samples y on the
// last cycle of each hold and compares it against the expected truth table.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - level; begins a sweep when idle or done
//   y         - output of the gate under test
//   a, b      - gate inputs; {a,b} always equals vec_idx
//   busy      - sweep in progress
//   done      - sweep finished; held until next start or reset
//   pass      - high with done when no vector mismatched
//   fail_mask - bit i set when the sample for vector i mismatched EXP_TT[i]
//   obs_tt    - bit i is the y sampled for vector i
//   vec_idx   - index of the vector currently applied
module gate_sweep_checker #(
  parameter logic [3:0]  EXP_TT = 4'b0111,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [3:0] obs_tt,
  output logic [1:0] vec_idx
);

  // A settle time of zero would never produce a sample edge; treat it as one.
  localparam int unsigned SettleEff = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [3:0]  CntLoad   = 4'(SettleEff - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic [3:0] obs_q, obs_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    obs_d   = obs_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          vec_d   = 2'd0;
          cnt_d   = CntLoad;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 4'd0;
          obs_d   = 4'd0;
        end
      end
      StRun: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          obs_d[vec_q]  = y;
          fail_d[vec_q] = (y != EXP_TT[vec_q]);
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
            cnt_d = CntLoad;
          end else begin
            // Last vector: pass must include the mismatch bit written this edge.
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_d == 4'd0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'd0;
      obs_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      obs_q   <= obs_d;
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign obs_tt    = obs_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a default-parameter instance whose y is driven
// by a selectable gate model (NAND, AND, constants or random), plus SETTLE=1
// and SETTLE=0 instances each wrapped around a NAND.
module tb_gate_sweep_checker;

  localparam int        L      = 2;
  localparam logic [3:0] EXP   = 4'b0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start_s;
  logic       rand_y;
  int         mode;

  logic       y, a, b, busy, done, pass;
  logic [3:0] fail_mask, obs_tt;
  logic [1:0] vec_idx;

  logic       y1, a1, b1, busy1, done1, pass1;
  logic [3:0] fail1, obs1;
  logic [1:0] vec1;
  logic       y0, a0, b0, busy0, done0, pass0;
  logic [3:0] fail0, obs0;
  logic [1:0] vec0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0 NAND, 1 AND, 2 tied high, 3 tied low, 4 random
  assign y  = (mode == 0) ? ~(a & b) :
              (mode == 1) ? (a & b)  :
              (mode == 2) ? 1'b1     :
              (mode == 3) ? 1'b0     : rand_y;
  assign y1 = ~(a1 & b1);
  assign y0 = ~(a0 & b0);

  gate_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .a(a), .b(b), .busy(busy),
    .done(done), .pass(pass), .fail_mask(fail_mask), .obs_tt(obs_tt), .vec_idx(vec_idx)
  );

  gate_sweep_checker #(.EXP_TT(4'b0111), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .y(y1), .a(a1), .b(b1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_mask(fail1), .obs_tt(obs1), .vec_idx(vec1)
  );

  gate_sweep_checker #(.EXP_TT(4'b0111), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .y(y0), .a(a0), .b(b0), .busy(busy0),
    .done(done0), .pass(pass0), .fail_mask(fail0), .obs_tt(obs0), .vec_idx(vec0)
  );

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] all_out();
    return {1'b0, a, b, busy, done, pass, fail_mask, obs_tt, vec_idx};
  endfunction

  // One full sweep on the main instance. The model knows only the sampling
  // schedule: vector i is applied for cycles [i*L, (i+1)*L) after the start
  // edge and sampled at edge S+(i+1)*L.
  task automatic do_sweep(input int md, input string tag);
    logic [3:0] exp_obs;
    logic       yv;
    int         exp_vec;
    mode = md;
    @(negedge clk);
    start  = 1'b1;
    rand_y = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({11'd0, busy, done, pass, vec_idx}, {11'd0, 1'b1, 1'b0, 1'b0, 2'd0},
        {tag, "_start"});
    chk({8'd0, fail_mask, obs_tt}, 16'd0, {tag, "_cleared"});
    exp_obs = 4'd0;
    for (int k = 1; k <= 4 * L; k++) begin
      rand_y = 1'($urandom);
      #1 yv = y;
      @(posedge clk);
      if (k % L == 0) exp_obs[k / L - 1] = yv;
      @(negedge clk);
      exp_vec = (k < 4 * L) ? k / L : 3;
      chk({13'd0, a, b, busy, done}, {13'd0, 2'(exp_vec), (k < 4 * L), (k == 4 * L)},
          $sformatf("%s_cyc%0d", tag, k));
    end
    chk({12'd0, obs_tt}, {12'd0, exp_obs}, {tag, "_obs_tt"});
    chk({12'd0, fail_mask}, {12'd0, exp_obs ^ EXP}, {tag, "_fail_mask"});
    chk({15'd0, pass}, {15'd0, ((exp_obs ^ EXP) == 4'd0)}, {tag, "_pass"});
  endtask

  initial begin
    int p;
    bit seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    rand_y  = 1'b0;
    mode    = 0;

    #1 chk(all_out(), 16'd0, "reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk(all_out(), 16'd0, "idle_after_reset");

    do_sweep(0, "nand");
    do_sweep(1, "and");
    do_sweep(2, "tie1");
    do_sweep(3, "tie0");

    // start held for 30 edges: sweeps restart every 4*L+1 cycles.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      p = k % (4 * L + 1);
      chk({13'd0, vec_idx, done}, {13'd0, (p == 4 * L) ? 2'd3 : 2'(p / L), (p == 4 * L)},
          $sformatf("held_cyc%0d", k));
    end
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = done;
    end
    chk({15'd0, done}, 16'd1, "held_final_done");
    chk({12'd0, obs_tt}, {12'd0, EXP}, "held_final_obs");

    // Asynchronous reset while vector 2 is applied.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * L) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk({14'd0, vec_idx}, 16'd2, "pre_reset_vec");
    #2 rst_n = 1'b0;
    #1 chk(all_out(), 16'd0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk(all_out(), 16'd0, $sformatf("post_reset_idle%0d", k));
    end

    // SETTLE=1 and SETTLE=0: one cycle per vector.
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({12'd0, vec1, done1, done0}, {12'd0, (k < 4) ? 2'(k) : 2'd3, (k == 4), (k == 4)},
          $sformatf("settle1_0_cyc%0d", k));
      chk({14'd0, vec0}, {14'd0, (k < 4) ? 2'(k) : 2'd3}, $sformatf("settle0_vec%0d", k));
    end
    chk({6'd0, pass1, pass0, obs1, obs0}, {6'd0, 1'b1, 1'b1, EXP, EXP}, "settle1_0_result");

    for (int r = 0; r < 4; r++) do_sweep(4, $sformatf("rand%0d", r));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
